// File: rtl/mvtr_err_mon.sv
// rtl/mvtr_err_mon.sv - multi-voter error monitor: classifies disagreements, timestamps and queues them
module mvtr_err_mon #(
    parameter int M       = 3,
    parameter int N       = 4,
    parameter int CW      = 16,
    parameter int TSW     = 32,
    parameter int DEPTH   = 8,
    parameter int PERSIST = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [M*N-1:0]         vtr_i,
    input  logic [N-1:0]           vtd_i,
    input  logic                   warn_i,
    input  logic                   clr_i,
    output logic                   ev_valid_o,
    input  logic                   ev_ready_i,
    output logic [TSW+M+N-1:0]     ev_data_o,
    output logic [M*CW-1:0]        err_cnt_o,
    output logic                   ovf_o,
    output logic                   persist_o
);

    localparam int EW = TSW + M + N;
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(PERSIST + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [RW-1:0] PERSIST_R = RW'(PERSIST);

    typedef enum logic [1:0] {S_IDLE, S_UPSET, S_PERSIST} state_t;

    logic [TSW-1:0] ts_q, ts_d;
    logic [M*N-1:0] vtr_q;
    logic [N-1:0]   vtd_q;
    logic           warn_q;
    logic [TSW-1:0] tsr_q;
    logic           pwarn_q, pwarn_d;
    logic [M+N-1:0] pmask_q, pmask_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  errc_q [M];
    logic [CW-1:0]  errc_d [M];
    state_t         state_q, state_d;
    logic [RW-1:0]  r_q, r_d;

    logic [M-1:0]   copy_mask;
    logic [N-1:0]   bit_mask;
    logic [N-1:0]   diff;
    logic           log_ev, push, pop, full;

    // Stage 2: which copies and which bits disagree with the trusted voted value
    always_comb begin
        copy_mask = '0;
        bit_mask  = '0;
        diff      = '0;
        for (int h = 0; h < M; h++) begin
            diff         = vtr_q[h*N +: N] ^ vtd_q;
            copy_mask[h] = |diff;
            bit_mask     = bit_mask | diff;
        end
    end

    assign log_ev     = warn_q & (~pwarn_q | ({copy_mask, bit_mask} != pmask_q));
    assign full       = (cnt_q == FULL_CNT);
    assign ev_valid_o = (cnt_q != '0);
    assign pop        = ev_valid_o & ev_ready_i;
    assign push       = log_ev & (~full | pop);

    always_comb begin
        ts_d    = ts_q + TSW'(1);
        pwarn_d = warn_q;
        pmask_d = {copy_mask, bit_mask};
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ovf_d   = ovf_q | (log_ev & ~push);
        for (int h = 0; h < M; h++) begin
            errc_d[h] = errc_q[h];
            if (log_ev && copy_mask[h] && (errc_q[h] != {CW{1'b1}}))
                errc_d[h] = errc_q[h] + CW'(1);
        end
        // Clear wins over any same-cycle push, pop or increment
        if (clr_i) begin
            pwarn_d = 1'b0;
            pmask_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            for (int h = 0; h < M; h++) errc_d[h] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q    <= '0;
            vtr_q   <= '0;
            vtd_q   <= '0;
            warn_q  <= 1'b0;
            tsr_q   <= '0;
            pwarn_q <= 1'b0;
            pmask_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            errc_q  <= '{default: '0};
        end else begin
            ts_q    <= ts_d;
            vtr_q   <= vtr_i;
            vtd_q   <= vtd_i;
            warn_q  <= warn_i;
            tsr_q   <= ts_q;
            pwarn_q <= pwarn_d;
            pmask_q <= pmask_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            errc_q  <= errc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) mem_q[wr_q] <= {tsr_q, copy_mask, bit_mask};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                r_d = '0;
                if (warn_q) begin
                    state_d = S_UPSET;
                    r_d     = RW'(1);
                end
            end
            S_UPSET: begin
                if (!warn_q) begin
                    state_d = S_IDLE;
                    r_d     = '0;
                end else begin
                    r_d = r_q + RW'(1);
                    if (r_q + RW'(1) == PERSIST_R) state_d = S_PERSIST;
                end
            end
            S_PERSIST: state_d = S_PERSIST;
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase
        if (clr_i) begin
            state_d = S_IDLE;
            r_d     = '0;
        end
    end

    // Entries are not reset, so the data port is gated to read 0 while empty
    always_comb begin
        persist_o = (state_q == S_PERSIST);
        ovf_o     = ovf_q;
        ev_data_o = ev_valid_o ? mem_q[rd_q] : '0;
        err_cnt_o = '0;
        for (int h = 0; h < M; h++) err_cnt_o[h*CW +: CW] = errc_q[h];
    end

endmodule

// File: tb/tb_mvtr_err_mon.sv
// tb/tb_mvtr_err_mon.sv - scoreboard bench for mvtr_err_mon
module tb_mvtr_err_mon;

    localparam int M = 3, N = 4, CW = 4, TSW = 32, DEPTH = 8, PERSIST = 16;
    localparam int EW = TSW + M + N;

    logic              clk = 1'b0;
    logic              rst, clr, warn, ready;
    logic [M*N-1:0]    vtr;
    logic [N-1:0]      vtd;
    logic              ev_valid, ovf, persist;
    logic [EW-1:0]     ev_data;
    logic [M*CW-1:0]   err_cnt;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    logic [EW-1:0] mf[$];

    logic [TSW-1:0] m_ts, m_tsr;
    logic [M*N-1:0] m_vtr;
    logic [N-1:0]   m_vtd, m_bm;
    logic [M-1:0]   m_cm;
    logic           m_warn, m_pw, m_log, m_pop;
    logic [M+N-1:0] m_pm;
    int             m_occ;

    mvtr_err_mon #(.M(M), .N(N), .CW(CW), .TSW(TSW), .DEPTH(DEPTH), .PERSIST(PERSIST)) dut (
        .clk_i(clk), .rst_i(rst), .vtr_i(vtr), .vtd_i(vtd), .warn_i(warn), .clr_i(clr),
        .ev_valid_o(ev_valid), .ev_ready_i(ready), .ev_data_o(ev_data),
        .err_cnt_o(err_cnt), .ovf_o(ovf), .persist_o(persist)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_cm = '0;
        m_bm = '0;
        for (int h = 0; h < M; h++) begin
            m_cm[h] = |(m_vtr[h*N +: N] ^ m_vtd);
            m_bm    = m_bm | (m_vtr[h*N +: N] ^ m_vtd);
        end
        m_log = m_warn && (!m_pw || ({m_cm, m_bm} != m_pm));
        m_pop = (m_occ > 0) && ready;
    end

    // Reference: pipeline, event rule and FIFO occupancy; popped entries go to exp_q
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ts <= '0; m_tsr <= '0; m_vtr <= '0; m_vtd <= '0; m_warn <= 1'b0;
            m_pw <= 1'b0; m_pm <= '0; m_occ <= 0;
            mf.delete();
        end else begin
            m_ts <= m_ts + 1; m_tsr <= m_ts; m_vtr <= vtr; m_vtd <= vtd; m_warn <= warn;
            if (clr) begin
                m_pw <= 1'b0; m_pm <= '0; m_occ <= 0;
                mf.delete();
            end else begin
                m_pw <= m_warn; m_pm <= {m_cm, m_bm};
                if (m_pop) exp_q.push_back(mf.pop_front());
                if (m_log && (m_occ < DEPTH || m_pop)) begin
                    mf.push_back({m_tsr, m_cm, m_bm});
                    m_occ <= m_occ + 1 - (m_pop ? 1 : 0);
                end else begin
                    m_occ <= m_occ - (m_pop ? 1 : 0);
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (ev_valid === 1'b1 && ready === 1'b1) got_q.push_back(ev_data);
    end

    task automatic drive(input logic [M*N-1:0] v, input logic [N-1:0] d, input logic w);
        @(negedge clk);
        vtr = v; vtd = d; warn = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1; vtr = '0; vtd = '0; warn = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; warn = 1'b0; ready = 1'b0; vtr = '0; vtd = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        tests++; if (ev_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", ev_data); end
        tests++; if (err_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %h want 0", err_cnt); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        tests++; if (persist !== 1'b0) begin fails++; $display("FAIL reset_persist: got %b want 0", persist); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [TSW-1:0] ts0;
        logic [EW-1:0]  want;
        ready = 1'b0;
        pulse_clr();
        drive(12'hAEA, 4'hA, 1'b1);
        ts0  = m_ts;
        want = {ts0, 3'b010, 4'b0100};
        idle(3);
        #2;
        tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", ev_valid); end
        tests++; if (ev_data !== want) begin fails++; $display("FAIL single_data: got %h want %h", ev_data, want); end
        tests++; if (err_cnt !== 12'h010) begin fails++; $display("FAIL single_cnt: got %h want 010", err_cnt); end
        tests++; if (persist !== 1'b0) begin fails++; $display("FAIL single_persist: got %b want 0", persist); end
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        #2;
        tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b want 0", ev_valid); end
    endtask

    task automatic test_hold();
        int g0;
        ready = 1'b1;
        pulse_clr();
        g0 = got_q.size();
        for (int k = 1; k <= 20; k++) begin
            drive(12'h455, 4'h5, 1'b1);
            #2;
            if (k == 17) begin
                tests++; if (persist !== 1'b0) begin fails++; $display("FAIL hold_early: got %b want 0", persist); end
            end
            if (k == 18) begin
                tests++; if (persist !== 1'b1) begin fails++; $display("FAIL hold_rise: got %b want 1", persist); end
            end
        end
        idle(5);
        #2;
        tests++; if (persist !== 1'b1) begin fails++; $display("FAIL hold_sticky: got %b want 1", persist); end
        tests++; if (err_cnt !== 12'h100) begin fails++; $display("FAIL hold_cnt: got %h want 100", err_cnt); end
        tests++; if (got_q.size() - g0 != 1) begin fails++; $display("FAIL hold_events: got %0d want 1", got_q.size() - g0); end
        if (got_q.size() > g0) begin
            tests++; if (got_q[g0][M+N-1:0] !== 7'b100_0001) begin fails++; $display("FAIL hold_mask: got %b want 1000001", got_q[g0][M+N-1:0]); end
        end
        pulse_clr();
        idle(1);
        #2;
        tests++; if (persist !== 1'b0) begin fails++; $display("FAIL hold_clr_persist: got %b want 0", persist); end
        tests++; if (err_cnt !== '0) begin fails++; $display("FAIL hold_clr_cnt: got %h want 0", err_cnt); end
    endtask

    task automatic test_backpressure();
        int g0;
        logic [EW-1:0] a, b;
        ready = 1'b0;
        pulse_clr();
        g0 = got_q.size();
        for (int i = 0; i < 9; i++) drive((i % 2 == 1) ? 12'h020 : 12'h001, 4'h0, 1'b1);
        idle(3);
        #2;
        tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", ev_valid); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL bp_ovf: got %b want 1", ovf); end
        tests++; if (err_cnt !== 12'h045) begin fails++; $display("FAIL bp_cnt: got %h want 045", err_cnt); end
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        #2;
        tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", ev_valid); end
        tests++; if (got_q.size() - g0 != 8) begin fails++; $display("FAIL bp_count: got %0d want 8", got_q.size() - g0); end
        if (got_q.size() - g0 == 8) begin
            a = got_q[g0];
            tests++; if (a[M+N-1:0] !== 7'b001_0001) begin fails++; $display("FAIL bp_first_mask: got %b want 0010001", a[M+N-1:0]); end
            for (int i = 0; i < 7; i++) begin
                a = got_q[g0 + i];
                b = got_q[g0 + i + 1];
                tests++;
                if (b[EW-1 -: TSW] !== a[EW-1 -: TSW] + 1) begin
                    fails++; $display("FAIL bp_ts_%0d: got %h want %h", i, b[EW-1 -: TSW], a[EW-1 -: TSW] + 1);
                end
            end
        end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL bp_ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_full_pop();
        int g0;
        logic [EW-1:0] a;
        ready = 1'b0;
        pulse_clr();
        g0 = got_q.size();
        for (int i = 0; i < 8; i++) drive((i % 2 == 1) ? 12'h020 : 12'h001, 4'h0, 1'b1);
        idle(3);
        drive(12'h100, 4'h0, 1'b1);
        @(negedge clk);
        ready = 1'b1; vtr = '0; vtd = '0; warn = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        idle(2);
        #2;
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL fp_ovf: got %b want 0", ovf); end
        tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL fp_valid: got %b want 1", ev_valid); end
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        #2;
        tests++; if (got_q.size() - g0 != 9) begin fails++; $display("FAIL fp_count: got %0d want 9", got_q.size() - g0); end
        if (got_q.size() > g0) begin
            a = got_q[got_q.size() - 1];
            tests++; if (a[M+N-1:0] !== 7'b100_0001) begin fails++; $display("FAIL fp_last_mask: got %b want 1000001", a[M+N-1:0]); end
        end
    endtask

    task automatic test_saturation();
        int g0;
        ready = 1'b1;
        pulse_clr();
        g0 = got_q.size();
        for (int i = 0; i < 20; i++) begin
            drive(12'h001, 4'h0, 1'b1);
            drive(12'h000, 4'h0, 1'b0);
            if (i == 9) begin
                idle(1);
                #2;
                tests++; if (err_cnt !== 12'h00A) begin fails++; $display("FAIL sat_mid: got %h want 00a", err_cnt); end
            end
        end
        idle(3);
        #2;
        tests++; if (err_cnt !== 12'h00F) begin fails++; $display("FAIL sat_final: got %h want 00f", err_cnt); end
        tests++; if (got_q.size() - g0 != 20) begin fails++; $display("FAIL sat_events: got %0d want 20", got_q.size() - g0); end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] want;
        ready = 1'b0;
        pulse_clr();
        for (int k = 0; k < 20; k++) drive(12'h455, 4'h5, 1'b1);
        for (int k = 0; k < 3; k++) drive(12'h545, 4'h5, 1'b1);
        idle(2);
        #2;
        tests++; if (persist !== 1'b1) begin fails++; $display("FAIL ar_pre_persist: got %b want 1", persist); end
        tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid: got %b want 1", ev_valid); end
        #1;
        rst = 1'b1;
        #1;
        tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b want 0", ev_valid); end
        tests++; if (ev_data !== '0) begin fails++; $display("FAIL ar_data: got %h want 0", ev_data); end
        tests++; if (persist !== 1'b0) begin fails++; $display("FAIL ar_persist: got %b want 0", persist); end
        tests++; if (err_cnt !== '0) begin fails++; $display("FAIL ar_cnt: got %h want 0", err_cnt); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ar_ovf: got %b want 0", ovf); end
        @(negedge clk);
        rst = 1'b0; vtr = 12'h001; vtd = 4'h0; warn = 1'b1;
        idle(3);
        #2;
        want = {32'd0, 3'b001, 4'b0001};
        tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL ar_post_valid: got %b want 1", ev_valid); end
        tests++; if (ev_data !== want) begin fails++; $display("FAIL ar_post_data: got %h want %h", ev_data, want); end
        tests++; if (err_cnt !== 12'h001) begin fails++; $display("FAIL ar_post_cnt: got %h want 001", err_cnt); end
        ready = 1'b1;
        idle(3);
        ready = 1'b0;
    endtask

    task automatic test_scoreboard();
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL sb_size: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL sb_entry_%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_backpressure();
        test_full_pop();
        test_saturation();
        test_async_reset();
        idle(2);
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
